// File: rtl/pingpong_sched.sv
// Ping-pong bank scheduler: waits for a load bank, swaps banks, streams tensor read
// addresses and result writes, then waits for the result drain. Optional macro PINGPONG_SCHED_PERF_EN.
`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module pingpong_sched (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   enable,
   input  logic                   start,
   input  logic [`TENSOR_SIZE-1:0] n_tensor_size,
   input  logic                   dma_w_last,
   input  logic                   dma_r_last,
   input  logic                   pe_ready,
   input  logic                   pe_res_vld,
   input  logic [`DATA_WIDTH-1:0] pe_res_data,
   output logic                   conv_en,
   output logic                   w_done,
   output logic [`ADDR_SIZE-1:0]  tensor_addr,
   output logic                   t_addr_vld,
   output logic [`ADDR_SIZE-1:0]  result_addr,
   output logic [`DATA_WIDTH-1:0] result_data,
   output logic                   result_w_ena,
   output logic                   result_w_vld,
   output logic                   busy
`ifdef PINGPONG_SCHED_PERF_EN
   ,
   output logic [31:0]            perf_cycles
`endif
);

   localparam int AW = `ADDR_SIZE;
   localparam int TW = `TENSOR_SIZE;
   localparam int CW = (TW > AW) ? TW : AW;

   typedef enum logic [1:0] {IDLE, WAIT_LOAD, COMPUTE, WAIT_DRAIN} state_t;

   state_t          state;
   logic [TW-1:0]   n_lat;
   logic [AW-1:0]   rd_cnt;
   logic [AW-1:0]   wr_cnt;
   logic            rd_end;
   logic            conv_en_q;
   logic            w_done_q;

   logic            act;
   logic            in_comp;
   logic [CW-1:0]   n_ext;
   logic [CW-1:0]   rd_ext;
   logic [CW-1:0]   wr_ext;
   logic            rd_fire;
   logic            rd_last;
   logic            wr_last;

   assign act     = enable & ~rstn;
   assign in_comp = (state == COMPUTE);
   assign n_ext   = CW'(n_lat);
   assign rd_ext  = CW'(rd_cnt);
   assign wr_ext  = CW'(wr_cnt);

   // Reads start one cycle after the swap pulse; rd_end keeps tensor_addr parked on N-1.
   assign t_addr_vld   = act & in_comp & ~conv_en_q & ~rd_end & (rd_ext < n_ext);
   assign rd_fire      = t_addr_vld & pe_ready;
   assign rd_last      = rd_fire & (rd_ext == n_ext - CW'(1));
   assign result_w_vld = act & in_comp & pe_res_vld & (wr_ext < n_ext);
   assign result_w_ena = result_w_vld;
   assign wr_last      = result_w_vld & (wr_ext == n_ext - CW'(1));
   assign result_data  = result_w_vld ? pe_res_data : '0;
   assign result_addr  = rstn ? '0 : wr_cnt;
   assign tensor_addr  = rstn ? '0 : rd_cnt;
   assign conv_en      = act & conv_en_q;
   assign w_done       = act & w_done_q;
   assign busy         = ~rstn & (state != IDLE);

   always_ff @(posedge clk) begin
      if (rstn) begin
         state     <= IDLE;
         n_lat     <= '0;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         rd_end    <= 1'b0;
         conv_en_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else if (enable) begin
         conv_en_q <= 1'b0;
         w_done_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= WAIT_LOAD;
                  n_lat <= n_tensor_size;
               end
            end
            WAIT_LOAD: begin
               if (dma_w_last) begin
                  state     <= COMPUTE;
                  conv_en_q <= 1'b1;
                  rd_cnt    <= '0;
                  wr_cnt    <= '0;
                  rd_end    <= 1'b0;
               end
            end
            COMPUTE: begin
               if (rd_fire) begin
                  if (rd_last) rd_end <= 1'b1;
                  else         rd_cnt <= rd_cnt + AW'(1);
               end
               if (result_w_vld) wr_cnt <= wr_cnt + AW'(1);
               // N=0 finishes straight away through the equality term.
               if (wr_last || (wr_ext == n_ext)) begin
                  w_done_q <= 1'b1;
                  state    <= WAIT_DRAIN;
               end
            end
            WAIT_DRAIN: begin
               if (dma_r_last) begin
                  if (start) begin
                     state <= WAIT_LOAD;
                     n_lat <= n_tensor_size;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PINGPONG_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (rstn) begin
         perf_cycles <= '0;
      end else if (enable && in_comp) begin
         if (conv_en_q)               perf_cycles <= '0;
         else if (perf_cycles != '1)  perf_cycles <= perf_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pingpong_sched.sv
// Directed bench for pingpong_sched: vector table for nominal and backpressure jobs,
// hand sequences for N=0, mid-job reset, enable pause and start-on-drain.
`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`timescale 1ns/1ps

module tb_pingpong_sched;
   localparam int AW = `ADDR_SIZE;
   localparam int TW = `TENSOR_SIZE;
   localparam int DW = `DATA_WIDTH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn, enable, start, dma_w_last, dma_r_last, pe_ready, pe_res_vld;
   logic [TW-1:0] n_tensor_size;
   logic [DW-1:0] pe_res_data;
   logic conv_en, w_done, t_addr_vld, result_w_ena, result_w_vld, busy;
   logic [AW-1:0] tensor_addr, result_addr;
   logic [DW-1:0] result_data;
`ifdef PINGPONG_SCHED_PERF_EN
   logic [31:0] perf_cycles;
`endif

   pingpong_sched dut (
      .clk(clk), .rstn(rstn), .enable(enable), .start(start),
      .n_tensor_size(n_tensor_size), .dma_w_last(dma_w_last), .dma_r_last(dma_r_last),
      .pe_ready(pe_ready), .pe_res_vld(pe_res_vld), .pe_res_data(pe_res_data),
      .conv_en(conv_en), .w_done(w_done), .tensor_addr(tensor_addr), .t_addr_vld(t_addr_vld),
      .result_addr(result_addr), .result_data(result_data), .result_w_ena(result_w_ena),
      .result_w_vld(result_w_vld), .busy(busy)
`ifdef PINGPONG_SCHED_PERF_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   typedef struct {
      logic rs, en, st; logic [TW-1:0] n; logic wl, rl, rdy, rv; logic [DW-1:0] d;
      logic e_cv, e_wd, e_tva; logic [AW-1:0] e_ta; logic e_wv; logic [AW-1:0] e_ra;
      logic [DW-1:0] e_rd; logic e_bz;
   } vec_t;

   vec_t tbl[$];
   int n_vec = 0;
   int n_bad = 0;
   int n_rd = 0;
   int n_wr = 0;
   logic [AW-1:0] addr_log[$];

   // Accepted reads/writes as seen at the clock edge.
   always @(posedge clk) begin
      if (t_addr_vld && pe_ready) begin
         n_rd++;
         addr_log.push_back(tensor_addr);
      end
      if (result_w_vld) n_wr++;
   end

   task automatic add(input logic rs, en, st, input int n, input logic wl, rl, rdy, rv, input int d,
                      input logic cv, wd, tva, input int ta, input logic wv, input int ra, input int rd, input logic bz);
      vec_t v;
      v.rs = rs; v.en = en; v.st = st; v.n = TW'(n); v.wl = wl; v.rl = rl; v.rdy = rdy; v.rv = rv;
      v.d = DW'(d); v.e_cv = cv; v.e_wd = wd; v.e_tva = tva; v.e_ta = AW'(ta); v.e_wv = wv;
      v.e_ra = AW'(ra); v.e_rd = DW'(rd); v.e_bz = bz;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic rs, en, st, input int n, input logic wl, rl, rdy, rv, input int d);
      rstn = rs; enable = en; start = st; n_tensor_size = TW'(n); dma_w_last = wl; dma_r_last = rl;
      pe_ready = rdy; pe_res_vld = rv; pe_res_data = DW'(d);
   endtask

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   initial begin
      int base_rd, base_wr;
      // rs en st n  wl rl rdy rv d      cv wd tva ta wv ra rd     bz
      add(1,1,0,0, 0,0,0,0,0,      0,0,0,0,0,0,0,0);
      add(1,1,0,0, 0,0,0,0,0,      0,0,0,0,0,0,0,0);
      add(0,1,1,4, 0,0,0,0,0,      0,0,0,0,0,0,0,0);
      add(0,1,0,0, 0,0,0,1,'h77,   0,0,0,0,0,0,0,1);
      add(0,1,0,0, 1,0,0,0,0,      0,0,0,0,0,0,0,1);
      add(0,1,0,0, 0,0,0,0,0,      1,0,0,0,0,0,0,1);
      add(0,1,0,0, 0,0,1,0,0,      0,0,1,0,0,0,0,1);
      add(0,1,0,0, 0,0,1,0,0,      0,0,1,1,0,0,0,1);
      add(0,1,0,0, 0,0,1,0,0,      0,0,1,2,0,0,0,1);
      add(0,1,0,0, 0,0,1,0,0,      0,0,1,3,0,0,0,1);
      add(0,1,0,0, 0,0,1,1,'hA0,   0,0,0,3,1,0,'hA0,1);
      add(0,1,0,0, 0,0,0,1,'hA1,   0,0,0,3,1,1,'hA1,1);
      add(0,1,0,0, 0,0,0,1,'hA2,   0,0,0,3,1,2,'hA2,1);
      add(0,1,0,0, 0,0,0,1,'hA3,   0,0,0,3,1,3,'hA3,1);
      add(0,1,0,0, 0,0,0,1,'hBB,   0,1,0,3,0,4,0,1);
      add(0,1,0,0, 0,0,0,0,0,      0,0,0,3,0,4,0,1);
      add(0,1,0,0, 0,1,0,0,0,      0,0,0,3,0,4,0,1);
      add(0,1,0,0, 0,0,0,0,0,      0,0,0,3,0,4,0,0);
      // backpressure, N=3, ready 1,0,1,0,1
      add(0,1,1,3, 0,0,0,0,0,      0,0,0,3,0,4,0,0);
      add(0,1,0,0, 1,0,0,0,0,      0,0,0,3,0,4,0,1);
      add(0,1,0,0, 0,0,0,0,0,      1,0,0,0,0,0,0,1);
      add(0,1,0,0, 0,0,1,0,0,      0,0,1,0,0,0,0,1);
      add(0,1,0,0, 0,0,0,0,0,      0,0,1,1,0,0,0,1);
      add(0,1,0,0, 0,0,1,0,0,      0,0,1,1,0,0,0,1);
      add(0,1,0,0, 0,0,0,0,0,      0,0,1,2,0,0,0,1);
      add(0,1,0,0, 0,0,1,0,0,      0,0,1,2,0,0,0,1);
      add(0,1,0,0, 0,0,0,0,0,      0,0,0,2,0,0,0,1);
      add(0,1,0,0, 0,0,0,1,'h10,   0,0,0,2,1,0,'h10,1);
      add(0,1,0,0, 0,0,0,1,'h11,   0,0,0,2,1,1,'h11,1);
      add(0,1,0,0, 0,0,0,1,'h12,   0,0,0,2,1,2,'h12,1);
      add(0,1,0,0, 0,0,0,0,0,      0,1,0,2,0,3,0,1);
      add(0,1,0,0, 0,1,0,0,0,      0,0,0,2,0,3,0,1);
      add(0,1,0,0, 0,0,0,0,0,      0,0,0,2,0,3,0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rs, tbl[i].en, tbl[i].st, int'(tbl[i].n), tbl[i].wl, tbl[i].rl, tbl[i].rdy, tbl[i].rv, int'(tbl[i].d));
         #1;
         chk($sformatf("vec%0d", i),
             64'({conv_en, w_done, t_addr_vld, tensor_addr, result_w_vld, result_w_ena, result_addr, result_data, busy}),
             64'({tbl[i].e_cv, tbl[i].e_wd, tbl[i].e_tva, tbl[i].e_ta, tbl[i].e_wv, tbl[i].e_wv, tbl[i].e_ra, tbl[i].e_rd, tbl[i].e_bz}));
         @(negedge clk);
      end

      // N=0: swap pulse, then w_done, with PE signals held active throughout
      drive(0,1,1,0, 0,0,0,0,0); @(negedge clk);
      drive(0,1,0,0, 1,0,0,0,0); @(negedge clk);
      base_rd = n_rd; base_wr = n_wr;
      drive(0,1,0,0, 0,0,1,1,'h55); #1;
      chk("n0_conv", 64'({conv_en, t_addr_vld, result_w_vld}), 64'(3'b100));
      @(negedge clk); #1;
      chk("n0_wdone", 64'({w_done, t_addr_vld, result_w_vld, busy}), 64'(4'b1001));
      @(negedge clk); #1;
      chk("n0_pulse", 64'(w_done), 64'(0));
      chk("n0_reads", 64'(n_rd - base_rd), 64'(0));
      chk("n0_writes", 64'(n_wr - base_wr), 64'(0));
      drive(0,1,0,0, 0,1,0,0,0); @(negedge clk);
      drive(0,1,0,0, 0,0,0,0,0); #1;
      chk("n0_idle", 64'(busy), 64'(0));

      // reset in COMPUTE after 2 of 4 writes
      drive(0,1,1,4, 0,0,0,0,0); @(negedge clk);
      drive(0,1,0,0, 1,0,0,0,0); @(negedge clk);
      drive(0,1,0,0, 0,0,0,0,0); @(negedge clk);
      drive(0,1,0,0, 0,0,0,1,'h1); @(negedge clk);
      drive(0,1,0,0, 0,0,0,1,'h2); #1;
      chk("rst_pre_addr", 64'(result_addr), 64'(1));
      @(negedge clk);
      drive(1,1,0,0, 0,0,1,1,'h3); #1;
      chk("rst_during", 64'({busy, t_addr_vld, result_w_vld, tensor_addr, result_addr}), 64'(0));
      @(negedge clk);
      base_wr = n_wr;
      drive(0,1,0,0, 0,0,1,1,'h4); #1;
      chk("rst_after", 64'({busy, conv_en, w_done, t_addr_vld, result_w_vld, result_w_ena, tensor_addr, result_addr, result_data}), 64'(0));
      @(negedge clk);
      chk("rst_nowrite", 64'(n_wr - base_wr), 64'(0));
      drive(0,1,0,0, 0,0,0,0,0); #1;
      chk("rst_idle", 64'(busy), 64'(0));

      // enable low for 3 cycles mid-COMPUTE
      drive(0,1,1,4, 0,0,0,0,0); @(negedge clk);
      drive(0,1,0,0, 1,0,0,0,0); @(negedge clk);
      drive(0,1,0,0, 0,0,0,0,0); @(negedge clk);
      addr_log.delete();
      drive(0,1,0,0, 0,0,1,0,0); @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         drive(0,0,0,0, 0,0,1,1,'h9); #1;
         chk($sformatf("en_hold%0d", k), 64'({tensor_addr, t_addr_vld, result_w_vld, conv_en, w_done, busy}), 64'({AW'(2), 5'b00001}));
         @(negedge clk);
      end
      drive(0,1,0,0, 0,0,1,0,0); @(negedge clk);
      @(negedge clk); #1;
      chk("en_tva_off", 64'(t_addr_vld), 64'(0));
      chk("en_nreads", 64'(addr_log.size()), 64'(4));
      for (int k = 0; k < 4; k++) begin
         if (k < addr_log.size()) chk($sformatf("en_addr%0d", k), 64'(addr_log[k]), 64'(k));
      end
      for (int k = 0; k < 4; k++) begin
         drive(0,1,0,0, 0,0,0,1,'h20 + k); @(negedge clk);
      end
      drive(0,1,0,0, 0,0,0,0,0); #1;
      chk("en_wdone", 64'({w_done, result_addr}), 64'({1'b1, AW'(4)}));
      @(negedge clk);

      // start coincident with dma_r_last in WAIT_DRAIN
      drive(0,1,1,2, 0,1,0,0,0); @(negedge clk);
      drive(0,1,0,0, 0,0,0,0,0); #1;
      chk("sd_busy", 64'(busy), 64'(1));
      @(negedge clk);
      drive(0,1,0,0, 1,0,0,0,0); @(negedge clk);
      drive(0,1,0,0, 0,0,0,0,0); #1;
      chk("sd_conv", 64'({conv_en, busy, tensor_addr, result_addr}), 64'({2'b11, AW'(0), AW'(0)}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
